// File: rtl/game_end_timer.sv
// ---------------------------------------------------------------------------
// game_end_timer
//
// Post-game stage behind the game master FSM. A one-cycle start pulse opens a
// fixed window of PRESCALE*TICKS clock cycles. The FSM stays in WON_END /
// LOST_END while the window is open. During the window a blink phase toggles
// every BLINK_TICKS ticks for the win/lose display. Saturating win and loss
// tallies feed the score display.
//
// Ports:
//   clk                        clock
//   reset                      asynchronous, active-high reset
//   end_of_game_timer_start    one-cycle pulse that opens (or restarts) the window
//   game_won                   sampled with start: 1 = won, 0 = lost
//   score_clear                synchronous clear of both tallies
//   end_of_game_timer_running  high for the whole window
//   result_won                 game_won as latched at the last start
//   blink                      display blink phase, 0 when idle
//   wins / losses              saturating tallies, SCORE_WIDTH bits each
// ---------------------------------------------------------------------------
module game_end_timer #(
    parameter int PRESCALE    = 1000000,
    parameter int TICKS       = 50,
    parameter int BLINK_TICKS = 5,
    parameter int SCORE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   end_of_game_timer_start,
    input  logic                   game_won,
    input  logic                   score_clear,
    output logic                   end_of_game_timer_running,
    output logic                   result_won,
    output logic                   blink,
    output logic [SCORE_WIDTH-1:0] wins,
    output logic [SCORE_WIDTH-1:0] losses
);

    // Counter widths, never narrower than one bit.
    localparam int PRE_W  = (PRESCALE    > 1) ? $clog2(PRESCALE)    : 1;
    localparam int TICK_W = (TICKS       > 1) ? $clog2(TICKS)       : 1;
    localparam int BL_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PRE_W-1:0]       PRE_LOAD  = PRE_W'(PRESCALE - 1);
    localparam logic [TICK_W-1:0]      TICK_LOAD = TICK_W'(TICKS - 1);
    localparam logic [BL_W-1:0]        BL_LOAD   = BL_W'(BLINK_TICKS - 1);
    localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]             r_state;
    logic [PRE_W-1:0]       r_pre;
    logic [TICK_W-1:0]      r_tick;
    logic [BL_W-1:0]        r_bl;
    logic                   r_blink;
    logic                   r_result_won;
    logic [SCORE_WIDTH-1:0] r_wins;
    logic [SCORE_WIDTH-1:0] r_losses;

    logic [SCORE_WIDTH-1:0] w_wins_base;
    logic [SCORE_WIDTH-1:0] w_losses_base;
    logic [SCORE_WIDTH-1:0] w_wins_next;
    logic [SCORE_WIDTH-1:0] w_losses_next;

    // Tally update: a coincident clear is applied first, then the start
    // increment, so clear+start leaves the counted tally at 1.
    // NOTE: every signal gets a default at the top of the always_comb block;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_wins_base   = score_clear ? '0 : r_wins;
        w_losses_base = score_clear ? '0 : r_losses;
        w_wins_next   = w_wins_base;
        w_losses_next = w_losses_base;
        if (end_of_game_timer_start) begin
            if (game_won) begin
                if (w_wins_base != SCORE_MAX)
                    w_wins_next = w_wins_base + SCORE_WIDTH'(1);
            end else begin
                if (w_losses_base != SCORE_MAX)
                    w_losses_next = w_losses_base + SCORE_WIDTH'(1);
            end
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pre        <= '0;
            r_tick       <= '0;
            r_bl         <= '0;
            r_blink      <= 1'b0;
            r_result_won <= 1'b0;
            r_wins       <= '0;
            r_losses     <= '0;
        end else begin
            r_wins   <= w_wins_next;
            r_losses <= w_losses_next;

            if (end_of_game_timer_start) begin
                // Start works in either state; during RUN it restarts the
                // window from full length.
                r_state      <= S_RUN;
                r_pre        <= PRE_LOAD;
                r_tick       <= TICK_LOAD;
                r_bl         <= BL_LOAD;
                r_blink      <= 1'b1;
                r_result_won <= game_won;
            end else if (r_state == S_RUN) begin
                if (r_pre != '0) begin
                    r_pre <= r_pre - PRE_W'(1);
                end else begin
                    r_pre <= PRE_LOAD;
                    if (r_tick == '0) begin
                        // Final tick closes the window even mid-half-period.
                        r_state <= S_IDLE;
                        r_blink <= 1'b0;
                    end else begin
                        r_tick <= r_tick - TICK_W'(1);
                        if (r_bl == '0) begin
                            r_bl    <= BL_LOAD;
                            r_blink <= ~r_blink;
                        end else begin
                            r_bl <= r_bl - BL_W'(1);
                        end
                    end
                end
            end
        end
    end

    assign end_of_game_timer_running = (r_state == S_RUN);
    assign result_won                = r_result_won;
    assign blink                     = r_blink;
    assign wins                      = r_wins;
    assign losses                    = r_losses;

endmodule

// File: tb/tb_game_end_timer.sv
// ---------------------------------------------------------------------------
// tb_game_end_timer
//
// Self-checking bench for game_end_timer. Instance A uses the reference
// parameter set (PRESCALE=4, TICKS=3, BLINK_TICKS=1, SCORE_WIDTH=2); instance B
// (PRESCALE=2, TICKS=5, BLINK_TICKS=2, SCORE_WIDTH=3) shares the inputs so
// multi-tick blink half-periods are exercised too. Expected behaviour comes
// from vector tables, hand-written corner sequences and an elapsed-time model.
// ---------------------------------------------------------------------------
module tb_game_end_timer;

    logic clk;
    logic reset;
    logic start;
    logic won;
    logic clr;

    logic       run_a, rw_a, blink_a;
    logic [1:0] wins_a, losses_a;
    logic       run_b, rw_b, blink_b;
    logic [2:0] wins_b, losses_b;

    game_end_timer #(.PRESCALE(4), .TICKS(3), .BLINK_TICKS(1), .SCORE_WIDTH(2)) dut_a (
        .clk                       (clk),
        .reset                     (reset),
        .end_of_game_timer_start   (start),
        .game_won                  (won),
        .score_clear               (clr),
        .end_of_game_timer_running (run_a),
        .result_won                (rw_a),
        .blink                     (blink_a),
        .wins                      (wins_a),
        .losses                    (losses_a)
    );

    game_end_timer #(.PRESCALE(2), .TICKS(5), .BLINK_TICKS(2), .SCORE_WIDTH(3)) dut_b (
        .clk                       (clk),
        .reset                     (reset),
        .end_of_game_timer_start   (start),
        .game_won                  (won),
        .score_clear               (clr),
        .end_of_game_timer_running (run_b),
        .result_won                (rw_b),
        .blink                     (blink_b),
        .wins                      (wins_b),
        .losses                    (losses_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Window state is described by the edge index of the last start; outputs
    // follow from elapsed cycles since that edge.
    int m_p[2]   = '{4, 2};
    int m_t[2]   = '{3, 5};
    int m_bt[2]  = '{1, 2};
    int m_max[2] = '{3, 7};
    int m_start[2];
    int m_won[2];
    int m_wins[2];
    int m_losses[2];
    int ec;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_start[i] = -1; m_won[i] = 0; m_wins[i] = 0; m_losses[i] = 0;
        end
        ec = 0;
    endtask

    task automatic model_edge(input logic st, input logic gw, input logic sc);
        for (int i = 0; i < 2; i++) begin
            if (sc) begin m_wins[i] = 0; m_losses[i] = 0; end
            if (st) begin
                m_start[i] = ec;
                m_won[i]   = gw;
                if (gw) m_wins[i]   = (m_wins[i]   < m_max[i]) ? m_wins[i] + 1   : m_max[i];
                else    m_losses[i] = (m_losses[i] < m_max[i]) ? m_losses[i] + 1 : m_max[i];
            end
        end
        ec++;
    endtask

    function automatic int exp_running(input int i);
        int el;
        if (m_start[i] < 0) return 0;
        el = ec - m_start[i];
        return (el >= 1 && el <= m_p[i] * m_t[i]) ? 1 : 0;
    endfunction

    function automatic int exp_blink(input int i);
        int ticks_done;
        if (exp_running(i) == 0) return 0;
        ticks_done = (ec - m_start[i] - 1) / m_p[i];
        return ((ticks_done / m_bt[i]) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic check_models(input string tag);
        check($sformatf("%s A running", tag), run_a,    exp_running(0));
        check($sformatf("%s A blink",   tag), blink_a,  exp_blink(0));
        check($sformatf("%s A won",     tag), rw_a,     m_won[0]);
        check($sformatf("%s A wins",    tag), wins_a,   m_wins[0]);
        check($sformatf("%s A losses",  tag), losses_a, m_losses[0]);
        check($sformatf("%s B running", tag), run_b,    exp_running(1));
        check($sformatf("%s B blink",   tag), blink_b,  exp_blink(1));
        check($sformatf("%s B won",     tag), rw_b,     m_won[1]);
        check($sformatf("%s B wins",    tag), wins_b,   m_wins[1]);
        check($sformatf("%s B losses",  tag), losses_b, m_losses[1]);
    endtask

    // ---------------- stimulus helpers ----------------
    // Called at a negedge: applies inputs to the next posedge, then returns at
    // the following negedge where outputs are stable.
    task automatic cycle(input logic st, input logic gw, input logic sc);
        start = st; won = gw; clr = sc;
        @(posedge clk);
        model_edge(st, gw, sc);
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic st;
        logic gw;
        logic sc;
        logic run;
        logic bl;
        int   wins;
        int   losses;
        logic rw;
    } vec_t;

    vec_t tbl[14];

    initial begin
        start = 1'b0; won = 1'b0; clr = 1'b0; reset = 1'b1;
        model_reset();
        do_reset();

        check("reset running", run_a,    0);
        check("reset blink",   blink_a,  0);
        check("reset won",     rw_a,     0);
        check("reset wins",    wins_a,   0);
        check("reset losses",  losses_a, 0);

        // 1/2: win then lose window. Row r is the input at edge r and the
        // output observed in cycle r+1.
        for (int pass = 0; pass < 2; pass++) begin
            for (int r = 0; r < 14; r++) begin
                tbl[r].st     = (r == 0);
                tbl[r].gw     = (pass == 0);
                tbl[r].sc     = 1'b0;
                tbl[r].run    = (r < 12);
                tbl[r].bl     = (r < 4) || (r >= 8 && r < 12);
                tbl[r].wins   = (pass == 0) ? 1 : 0;
                tbl[r].losses = (pass == 0) ? 0 : 1;
                tbl[r].rw     = (pass == 0);
            end
            if (pass == 1) do_reset();
            for (int r = 0; r < 14; r++) begin
                cycle(tbl[r].st, tbl[r].gw, tbl[r].sc);
                check($sformatf("tbl%0d c%0d running", pass, r + 1), run_a,    tbl[r].run);
                check($sformatf("tbl%0d c%0d blink",   pass, r + 1), blink_a,  tbl[r].bl);
                check($sformatf("tbl%0d c%0d wins",    pass, r + 1), wins_a,   tbl[r].wins);
                check($sformatf("tbl%0d c%0d losses",  pass, r + 1), losses_a, tbl[r].losses);
                check($sformatf("tbl%0d c%0d won",     pass, r + 1), rw_a,     tbl[r].rw);
            end
        end

        // 3: saturation, each start after the previous window closes.
        do_reset();
        for (int g = 0; g < 5; g++) begin
            cycle(1'b1, 1'b1, 1'b0);
            check($sformatf("sat game%0d wins", g), wins_a, (g < 3) ? g + 1 : 3);
            for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, 1'b0);
            check($sformatf("sat game%0d closed", g), run_a, 0);
        end

        // 4: retrigger at edge 6 keeps the window open through cycle 18.
        do_reset();
        for (int k = 0; k < 19; k++) begin
            cycle((k == 0) || (k == 6), 1'b1, 1'b0);
            check($sformatf("retrig c%0d running", k + 1), run_a, (k + 1 <= 18) ? 1 : 0);
        end
        check("retrig wins", wins_a, 2);

        // 5: clear coinciding with a lost start.
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, (k < 3), 1'b0);
        check("pre-clear wins",   wins_a,   3);
        check("pre-clear losses", losses_a, 2);
        cycle(1'b1, 1'b0, 1'b1);
        check("clear+start wins",   wins_a,   0);
        check("clear+start losses", losses_a, 1);
        check("clear+start won",    rw_a,     0);
        check("clear+start running", run_a,   1);

        // 6: asynchronous reset in the middle of a window.
        do_reset();
        cycle(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 1'b0);
        check("pre-reset running", run_a, 1);
        #2 reset = 1'b1;
        #1;
        check("async reset running", run_a,    0);
        check("async reset blink",   blink_a,  0);
        check("async reset wins",    wins_a,   0);
        check("async reset losses",  losses_a, 0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            cycle(1'b0, 1'b0, 1'b0);
            check($sformatf("post-reset c%0d running", k), run_a, 0);
        end

        // Randomised traffic against the model on both instances.
        do_reset();
        for (int k = 0; k < 800; k++) begin
            cycle(($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0));
            check_models($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
